mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage directly downstream of EX, upstream of WB.
- Registers the EX payload and issues load/store requests on a req/addr_ok/data_ok data-memory bus.
- Aligns and extends load data, flags misaligned accesses, and presents the result to WB under a valid/ready handshake.

Parameters:
- DATA_W, 32, data and address width.
- REG_W, 5, register-file address width.
- LSU_OP_W, 4, lsu_op width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  kill the in-flight instruction (exception/ertn)
- in_valid  in  1  EX payload valid
- in_ready  out  1  stage can accept a payload this cycle
- in_pc  in  DATA_W  instruction PC
- in_ex_result  in  DATA_W  ALU result; memory address for LSU ops
- in_lsu_op  in  LSU_OP_W  memory operation
- in_lsu_data  in  DATA_W  store data
- in_rw_en  in  1  register write enable
- in_rw_addr  in  REG_W  destination register
- in_except_type  in  10  exceptions accumulated so far
- data_req  out  1  memory request
- data_wr  out  1  1 = store
- data_size  out  2  0 = byte, 1 = half, 2 = word
- data_wstrb  out  4  byte enables
- data_addr  out  DATA_W  request address
- data_wdata  out  DATA_W  store data, replicated per lane
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  response/ack valid
- data_rdata  in  DATA_W  load data
- out_valid  out  1  WB payload valid
- out_ready  in  1  WB accepts
- out_pc  out  DATA_W  PC
- out_result  out  DATA_W  load data or passed-through ALU result
- out_rw_en  out  1  register write enable; forced 0 on exception
- out_rw_addr  out  REG_W  destination register
- out_except_type  out  10  exceptions, ALE bit (bit 6) merged in

Behaviour:
- Reset: state IDLE; every output 0 except in_ready = 1.
- Encodings (pkg): NONE=0, LD_B=1, LD_H=2, LD_W=3, LD_BU=4, LD_HU=5, ST_B=6, ST_H=7, ST_W=8.
- Accept when in_valid && in_ready. in_ready = (state==IDLE) || (state==DONE && out_ready).
- FSM states: IDLE, REQ, WAIT, DONE, DRAIN.
  - Accept, non-LSU op, or LSU op with incoming exception, or misaligned -> DONE next cycle. No bus request is issued.
  - Accept, aligned LSU op with no exception -> REQ.
  - REQ: data_req = 1, all bus fields held stable. On addr_ok -> WAIT.
  - WAIT: on data_ok -> DONE. A load latches the extended rdata into out_result.
  - DONE: out_valid = 1. On out_ready, go to IDLE, or reload straight to REQ/DONE if a new payload is accepted in the same cycle.
- Non-LSU latency is 1 cycle; LSU is 1 + bus latency.
- Misalignment (ALE): half with addr[0] != 0, or word with addr[1:0] != 0. Sets ALE and clears out_rw_en.
- Load extension from addr[1:0] lane. LD_B/LD_H sign-extend; BU/HU zero-extend.
- Store wstrb: ST_B = 1<<addr[1:0]; ST_H = 0011 or 1100; ST_W = 1111.
- flush in IDLE/REQ/DONE: state goes to IDLE and out_valid drops. A request in REQ is withdrawn only if addr_ok is not asserted that same cycle.
- flush in WAIT, or in REQ with addr_ok that cycle: -> DRAIN. DRAIN discards the next data_ok, then goes to IDLE. in_ready = 0 while in DRAIN.
- The bus never sees a second request before the outstanding data_ok.
- data_ok arriving in REQ is illegal; the bench asserts it never happens.

Optional Feature:
- Macro MEM_STAGE_FWD_EN.
- Defined: extra outputs fwd_valid (1), fwd_addr (REG_W), fwd_data (DATA_W), fwd_stall (1) feed the ID bypass network.
  - fwd_valid is asserted in DONE with out_rw_en.
  - fwd_stall = 1 while a load with rw_en is in REQ/WAIT.
- Undefined: these ports do not exist. Hazards are resolved upstream by interlock only.

Decomposition:
- Package mem_stage_pkg:
  - lsu_op enumeration.
  - state_e.
  - ALE bit index.
  - Size encodings.
  - Function is_load/is_store.
- Sub-module mem_load_align: combinational rdata/addr/op -> extended result. Reused by the store-data replicator.

Test Plan:
- ALU op (rw_en=1, rd=5, result 0x1234), out_ready=1 -> out_valid one cycle later with out_result 0x1234. No data_req.
- LD_B at addr 0x1003 with rdata 0x80FF_0000 -> out_result 0xFFFFFF80. LD_BU at the same address -> 0x00000080.
- ST_H at 0x2002, lsu_data 0xABCD -> wstrb 1100, wdata 0xABCDABCD, data_size 1, data_wr 1. addr_ok delayed 3 cycles, and the bus fields are held during the wait.
- LD_W at 0x3001 -> no data_req, ALE set, out_rw_en 0.
- LD_W accepted, addr_ok given, flush during WAIT -> DRAIN. data_ok after 4 cycles is discarded, out_valid never rises, then in_ready returns to 1.
- out_ready held low for 5 cycles in DONE -> outputs stable and in_ready 0. Release with a new in_valid -> back-to-back accept in the same cycle.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
// Shared types and helpers for the memory-access pipeline stage.
//   lsu_op_e  : memory operation encoding carried from EX
//   state_e   : MEM stage control FSM states
//   ALE_BIT   : position of the address-misalignment flag in except_type
//   SIZE_*    : data_size encodings on the data-memory bus
//   is_load / is_store / op_size / is_misaligned : op classification helpers
package mem_stage_pkg;

    localparam int EXCEPT_W = 10;
    localparam int ALE_BIT  = 6;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [3:0] {
        LSU_NONE  = 4'd0,
        LSU_LD_B  = 4'd1,
        LSU_LD_H  = 4'd2,
        LSU_LD_W  = 4'd3,
        LSU_LD_BU = 4'd4,
        LSU_LD_HU = 4'd5,
        LSU_ST_B  = 4'd6,
        LSU_ST_H  = 4'd7,
        LSU_ST_W  = 4'd8
    } lsu_op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_e;

    function automatic logic is_load(input lsu_op_e op);
        return (op == LSU_LD_B) || (op == LSU_LD_H) || (op == LSU_LD_W) ||
               (op == LSU_LD_BU) || (op == LSU_LD_HU);
    endfunction

    function automatic logic is_store(input lsu_op_e op);
        return (op == LSU_ST_B) || (op == LSU_ST_H) || (op == LSU_ST_W);
    endfunction

    function automatic logic [1:0] op_size(input lsu_op_e op);
        case (op)
            LSU_LD_H, LSU_LD_HU, LSU_ST_H: return SIZE_HALF;
            LSU_LD_W, LSU_ST_W:            return SIZE_WORD;
            default:                       return SIZE_BYTE;
        endcase
    endfunction

    // Byte accesses can never be misaligned; halves need addr[0]==0,
    // words need addr[1:0]==0.
    function automatic logic is_misaligned(input lsu_op_e op, input logic [1:0] addr_lo);
        case (op_size(op))
            SIZE_HALF: return addr_lo[0];
            SIZE_WORD: return |addr_lo;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align
// Combinational lane steering for the memory stage.
//   data    : in  DATA_W  raw bus word (load) or store data (store)
//   addr_lo : in  2       low address bits selecting the byte/half lane
//   op      : in  lsu_op_e memory operation
//   result  : out DATA_W  load ops: selected lane, sign/zero extended;
//                         store ops: low byte/half replicated to every lane;
//                         anything else: data passed through
// The same block serves both the load-result path and the store-data
// replicator, so the lane conventions live in one place.
module mem_load_align
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        addr_lo,
    input  lsu_op_e           op,
    output logic [DATA_W-1:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Pick the addressed byte and half-word, then extend or replicate.
    always_comb begin
        case (addr_lo)
            2'd0:    lane_b = data[7:0];
            2'd1:    lane_b = data[15:8];
            2'd2:    lane_b = data[23:16];
            default: lane_b = data[31:24];
        endcase
        lane_h = addr_lo[1] ? data[31:16] : data[15:0];

        result = data;
        case (op)
            LSU_LD_B:  result = {{(DATA_W-8){lane_b[7]}}, lane_b};
            LSU_LD_BU: result = {{(DATA_W-8){1'b0}}, lane_b};
            LSU_LD_H:  result = {{(DATA_W-16){lane_h[15]}}, lane_h};
            LSU_LD_HU: result = {{(DATA_W-16){1'b0}}, lane_h};
            LSU_ST_B:  result = {(DATA_W/8){data[7:0]}};
            LSU_ST_H:  result = {(DATA_W/16){data[15:0]}};
            default:   result = data;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage
// Memory-access pipeline stage between EX and WB. Registers the EX payload,
// issues load/store requests on a req/addr_ok/data_ok bus, aligns and
// extends load data, flags misaligned accesses (ALE) and hands the result
// to WB under valid/ready.
//
// Ports:
//   clk, rst_n (synchronous, active low), flush (kill in-flight instruction)
//   in_*     : EX payload with in_valid/in_ready handshake
//   data_*   : data-memory bus (req, wr, size, wstrb, addr, wdata, addr_ok,
//              data_ok, rdata)
//   out_*    : WB payload with out_valid/out_ready handshake
//
// Optional build macro MEM_STAGE_FWD_EN adds fwd_valid/fwd_addr/fwd_data/
// fwd_stall for the ID bypass network. Without it, hazards are handled by
// the upstream interlock and these ports do not exist.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5,
    parameter int LSU_OP_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,

    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_pc,
    input  logic [DATA_W-1:0]   in_ex_result,
    input  logic [LSU_OP_W-1:0] in_lsu_op,
    input  logic [DATA_W-1:0]   in_lsu_data,
    input  logic                in_rw_en,
    input  logic [REG_W-1:0]    in_rw_addr,
    input  logic [EXCEPT_W-1:0] in_except_type,

    output logic                data_req,
    output logic                data_wr,
    output logic [1:0]          data_size,
    output logic [3:0]          data_wstrb,
    output logic [DATA_W-1:0]   data_addr,
    output logic [DATA_W-1:0]   data_wdata,
    input  logic                data_addr_ok,
    input  logic                data_data_ok,
    input  logic [DATA_W-1:0]   data_rdata,

    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_pc,
    output logic [DATA_W-1:0]   out_result,
    output logic                out_rw_en,
    output logic [REG_W-1:0]    out_rw_addr,
    output logic [EXCEPT_W-1:0] out_except_type
`ifdef MEM_STAGE_FWD_EN
    ,
    output logic                fwd_valid,
    output logic [REG_W-1:0]    fwd_addr,
    output logic [DATA_W-1:0]   fwd_data,
    output logic                fwd_stall
`endif
);

    state_e              state;
    lsu_op_e             r_op;
    logic [DATA_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_lsu_data;

    lsu_op_e             in_op;
    logic                accept;
    logic                take;
    logic                in_misaligned;
    logic                in_goes_to_bus;
    logic [EXCEPT_W-1:0] in_except_merged;
    logic [DATA_W-1:0]   load_result;

    assign in_op    = lsu_op_e'(in_lsu_op[3:0]);
    assign in_ready = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    // A payload offered in the same cycle as a flush belongs to the flushed
    // path too, so it is dropped rather than loaded.
    assign take     = accept && !flush;

    assign in_misaligned = is_misaligned(in_op, in_ex_result[1:0]);

    // Merge ALE into the incoming exception vector; any exception at all
    // keeps the access off the bus and suppresses the register write.
    always_comb begin
        in_except_merged = in_except_type;
        if (in_misaligned) begin
            in_except_merged[ALE_BIT] = 1'b1;
        end
    end

    assign in_goes_to_bus = (is_load(in_op) || is_store(in_op)) &&
                            (in_except_merged == '0);

    // Bus fields come straight from the payload registers, so they stay
    // stable for as long as the request waits for addr_ok.
    assign data_req  = (state == S_REQ);
    assign data_wr   = is_store(r_op);
    assign data_size = op_size(r_op);
    assign data_addr = r_addr;
    assign out_valid = (state == S_DONE);

    // Store byte enables from the access size and address lane.
    always_comb begin
        case (r_op)
            LSU_ST_B: data_wstrb = 4'b0001 << r_addr[1:0];
            LSU_ST_H: data_wstrb = r_addr[1] ? 4'b1100 : 4'b0011;
            LSU_ST_W: data_wstrb = 4'b1111;
            default:  data_wstrb = 4'b0000;
        endcase
    end

    mem_load_align #(.DATA_W(DATA_W)) u_load_align (
        .data    (data_rdata),
        .addr_lo (r_addr[1:0]),
        .op      (r_op),
        .result  (load_result)
    );

    mem_load_align #(.DATA_W(DATA_W)) u_store_repl (
        .data    (r_lsu_data),
        .addr_lo (r_addr[1:0]),
        .op      (r_op),
        .result  (data_wdata)
    );

    // Control FSM plus payload registers. Once addr_ok has been seen the
    // response must still be consumed, so a flush from then on parks in
    // DRAIN until the orphan data_ok arrives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            r_op            <= LSU_NONE;
            r_addr          <= '0;
            r_lsu_data      <= '0;
            out_pc          <= '0;
            out_result      <= '0;
            out_rw_en       <= 1'b0;
            out_rw_addr     <= '0;
            out_except_type <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (take) begin
                        state <= in_goes_to_bus ? S_REQ : S_DONE;
                    end
                end
                S_REQ: begin
                    if (flush) begin
                        state <= data_addr_ok ? S_DRAIN : S_IDLE;
                    end else if (data_addr_ok) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (data_data_ok) begin
                        state <= flush ? S_IDLE : S_DONE;
                        if (!flush && is_load(r_op)) begin
                            out_result <= load_result;
                        end
                    end else if (flush) begin
                        state <= S_DRAIN;
                    end
                end
                S_DONE: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else if (out_ready) begin
                        if (take) begin
                            state <= in_goes_to_bus ? S_REQ : S_DONE;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (data_data_ok) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (take) begin
                r_op            <= in_op;
                r_addr          <= in_ex_result;
                r_lsu_data      <= in_lsu_data;
                out_pc          <= in_pc;
                out_result      <= in_ex_result;
                out_rw_en       <= in_rw_en && (in_except_merged == '0);
                out_rw_addr     <= in_rw_addr;
                out_except_type <= in_except_merged;
            end
        end
    end

`ifdef MEM_STAGE_FWD_EN
    // Bypass: result is forwardable once in DONE; a load still on the bus
    // must stall any dependent instruction in ID.
    assign fwd_valid = (state == S_DONE) && out_rw_en;
    assign fwd_addr  = out_rw_addr;
    assign fwd_data  = out_result;
    assign fwd_stall = ((state == S_REQ) || (state == S_WAIT)) &&
                       is_load(r_op) && out_rw_en;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage
// Directed self-checking bench for mem_stage: reset, ALU pass-through,
// load extension, store strobes/replication with a slow addr_ok, ALE,
// flush in REQ/WAIT/DONE and back-to-back accept under WB backpressure.
// A bus monitor flags data_ok during an open request and a second request
// while one is outstanding.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_ex_result;
    logic [3:0]  in_lsu_op;
    logic [31:0] in_lsu_data;
    logic        in_rw_en;
    logic [4:0]  in_rw_addr;
    logic [9:0]  in_except_type;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_result;
    logic        out_rw_en;
    logic [4:0]  out_rw_addr;
    logic [9:0]  out_except_type;
`ifdef MEM_STAGE_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
    logic        fwd_stall;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    logic outstanding = 1'b0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_ex_result(in_ex_result), .in_lsu_op(in_lsu_op), .in_lsu_data(in_lsu_data),
        .in_rw_en(in_rw_en), .in_rw_addr(in_rw_addr), .in_except_type(in_except_type),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_result(out_result), .out_rw_en(out_rw_en), .out_rw_addr(out_rw_addr),
        .out_except_type(out_except_type)
`ifdef MEM_STAGE_FWD_EN
        ,
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .fwd_stall(fwd_stall)
`endif
    );

    // Bus protocol monitor
    always @(posedge clk) begin
        if (!rst_n) begin
            outstanding = 1'b0;
        end else begin
            if (data_req && data_data_ok) begin
                tests_failed++;
                $display("[TB] FAIL bus_data_ok_in_req at %0t: data_ok=1 while data_req=1, required 0", $time);
            end
            if (data_req && outstanding) begin
                tests_failed++;
                $display("[TB] FAIL bus_second_req at %0t: data_req=1 with response outstanding, required 0", $time);
            end
            if (data_req && data_addr_ok) outstanding = 1'b1;
            else if (data_data_ok) outstanding = 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_payload(input logic [3:0] op, input logic [31:0] pc,
                                 input logic [31:0] addr, input logic [31:0] sdata,
                                 input logic rw_en, input logic [4:0] rd,
                                 input logic [9:0] exc);
        in_valid       = 1'b1;
        in_lsu_op      = op;
        in_pc          = pc;
        in_ex_result   = addr;
        in_lsu_data    = sdata;
        in_rw_en       = rw_en;
        in_rw_addr     = rd;
        in_except_type = exc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_pc = '0; in_ex_result = '0; in_lsu_op = '0; in_lsu_data = '0;
        in_rw_en = 1'b0; in_rw_addr = '0; in_except_type = '0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
        tests_run++; if (data_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_data_req got %b want 0", data_req); end
        tests_run++; if (data_wstrb !== 4'b0000) begin tests_failed++; $display("[TB] FAIL reset_wstrb got %b want 0000", data_wstrb); end
        tests_run++; if (out_result !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_out_result got %h want 0", out_result); end
        tests_run++; if (out_except_type !== 10'h0) begin tests_failed++; $display("[TB] FAIL reset_except got %h want 0", out_except_type); end
        tests_run++; if (out_rw_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rw_en got %b want 0", out_rw_en); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        out_ready = 1'b1;
        drive_payload(LSU_NONE, 32'h0000_0100, 32'h0000_1234, 32'h0, 1'b1, 5'd5, 10'h0);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL alu_out_valid got %b want 1", out_valid); end
        tests_run++; if (out_result !== 32'h1234) begin tests_failed++; $display("[TB] FAIL alu_result got %h want 00001234", out_result); end
        tests_run++; if (out_rw_en !== 1'b1) begin tests_failed++; $display("[TB] FAIL alu_rw_en got %b want 1", out_rw_en); end
        tests_run++; if (out_rw_addr !== 5'd5) begin tests_failed++; $display("[TB] FAIL alu_rw_addr got %0d want 5", out_rw_addr); end
        tests_run++; if (out_pc !== 32'h100) begin tests_failed++; $display("[TB] FAIL alu_pc got %h want 00000100", out_pc); end
        tests_run++; if (data_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL alu_no_req got %b want 0", data_req); end
        tick();
        @(negedge clk);
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL alu_drop_valid got %b want 0", out_valid); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL alu_idle_ready got %b want 1", in_ready); end
    endtask

    task automatic test_load_ext();
        logic [3:0]  ops   [6] = '{LSU_LD_B, LSU_LD_BU, LSU_LD_H, LSU_LD_HU, LSU_LD_B, LSU_LD_W};
        logic [31:0] addrs [6] = '{32'h1003, 32'h1003, 32'h1002, 32'h1002, 32'h1002, 32'h1000};
        logic [1:0]  sizes [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd2};
        logic [31:0] exps  [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                                   32'h0000_80FF, 32'hFFFF_FFFF, 32'h80FF_0000};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_payload(ops[i], 32'h200, addrs[i], 32'h0, 1'b1, 5'd6, 10'h0);
            tick();
            in_valid = 1'b0;
            @(negedge clk);
            tests_run++; if (data_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL ld%0d_req got %b want 1", i, data_req); end
            tests_run++; if (data_wr !== 1'b0) begin tests_failed++; $display("[TB] FAIL ld%0d_wr got %b want 0", i, data_wr); end
            tests_run++; if (data_addr !== addrs[i]) begin tests_failed++; $display("[TB] FAIL ld%0d_addr got %h want %h", i, data_addr, addrs[i]); end
            tests_run++; if (data_size !== sizes[i]) begin tests_failed++; $display("[TB] FAIL ld%0d_size got %0d want %0d", i, data_size, sizes[i]); end
            data_addr_ok = 1'b1;
            tick();
            data_addr_ok = 1'b0;
            @(negedge clk);
            tests_run++; if (data_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL ld%0d_req_drop got %b want 0", i, data_req); end
            data_data_ok = 1'b1;
            data_rdata   = 32'h80FF_0000;
            tick();
            data_data_ok = 1'b0;
            data_rdata   = 32'h0;
            @(negedge clk);
            tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL ld%0d_valid got %b want 1", i, out_valid); end
            tests_run++; if (out_result !== exps[i]) begin tests_failed++; $display("[TB] FAIL ld%0d_result got %h want %h", i, out_result, exps[i]); end
            tests_run++; if (out_rw_en !== 1'b1) begin tests_failed++; $display("[TB] FAIL ld%0d_rw_en got %b want 1", i, out_rw_en); end
            tick();
        end
    endtask

    task automatic test_store();
        logic [3:0]  ops   [2] = '{LSU_ST_B, LSU_ST_W};
        logic [31:0] addrs [2] = '{32'h2001, 32'h2004};
        logic [31:0] sdat  [2] = '{32'h1234_56EF, 32'hDEAD_BEEF};
        logic [3:0]  strb  [2] = '{4'b0010, 4'b1111};
        logic [31:0] wdat  [2] = '{32'hEFEF_EFEF, 32'hDEAD_BEEF};
        logic [1:0]  sizes [2] = '{2'd0, 2'd2};
        out_ready = 1'b1;
        drive_payload(LSU_ST_H, 32'h300, 32'h2002, 32'h0000_ABCD, 1'b0, 5'd0, 10'h0);
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests_run++; if (data_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL sth_req_c%0d got %b want 1", c, data_req); end
            tests_run++; if (data_wr !== 1'b1) begin tests_failed++; $display("[TB] FAIL sth_wr_c%0d got %b want 1", c, data_wr); end
            tests_run++; if (data_size !== 2'd1) begin tests_failed++; $display("[TB] FAIL sth_size_c%0d got %0d want 1", c, data_size); end
            tests_run++; if (data_wstrb !== 4'b1100) begin tests_failed++; $display("[TB] FAIL sth_wstrb_c%0d got %b want 1100", c, data_wstrb); end
            tests_run++; if (data_wdata !== 32'hABCD_ABCD) begin tests_failed++; $display("[TB] FAIL sth_wdata_c%0d got %h want abcdabcd", c, data_wdata); end
            tests_run++; if (data_addr !== 32'h2002) begin tests_failed++; $display("[TB] FAIL sth_addr_c%0d got %h want 00002002", c, data_addr); end
            tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL sth_in_ready_c%0d got %b want 0", c, in_ready); end
            tick();
        end
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        @(negedge clk);
        tests_run++; if (data_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL sth_req_drop got %b want 0", data_req); end
        data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;
        @(negedge clk);
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL sth_valid got %b want 1", out_valid); end
        tests_run++; if (out_result !== 32'h2002) begin tests_failed++; $display("[TB] FAIL sth_result got %h want 00002002", out_result); end
        tests_run++; if (out_rw_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL sth_rw_en got %b want 0", out_rw_en); end
        tick();
        for (int i = 0; i < 2; i++) begin
            drive_payload(ops[i], 32'h310, addrs[i], sdat[i], 1'b0, 5'd0, 10'h0);
            tick();
            in_valid = 1'b0;
            @(negedge clk);
            tests_run++; if (data_wstrb !== strb[i]) begin tests_failed++; $display("[TB] FAIL st%0d_wstrb got %b want %b", i, data_wstrb, strb[i]); end
            tests_run++; if (data_wdata !== wdat[i]) begin tests_failed++; $display("[TB] FAIL st%0d_wdata got %h want %h", i, data_wdata, wdat[i]); end
            tests_run++; if (data_size !== sizes[i]) begin tests_failed++; $display("[TB] FAIL st%0d_size got %0d want %0d", i, data_size, sizes[i]); end
            data_addr_ok = 1'b1;
            tick();
            data_addr_ok = 1'b0;
            data_data_ok = 1'b1;
            tick();
            data_data_ok = 1'b0;
            @(negedge clk);
            tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL st%0d_valid got %b want 1", i, out_valid); end
            tick();
        end
    endtask

    task automatic test_misaligned();
        logic [3:0]  ops   [4] = '{LSU_LD_W, LSU_ST_H, LSU_LD_H, LSU_LD_HU};
        logic [31:0] addrs [4] = '{32'h3001, 32'h3003, 32'h3002, 32'h3001};
        logic [9:0]  excin [4] = '{10'h000, 10'h000, 10'h001, 10'h004};
        logic [9:0]  exps  [4] = '{10'h040, 10'h040, 10'h001, 10'h044};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_payload(ops[i], 32'h400, addrs[i], 32'h5A5A_5A5A, 1'b1, 5'd8, excin[i]);
            tick();
            in_valid = 1'b0;
            @(negedge clk);
            tests_run++; if (data_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL exc%0d_no_req got %b want 0", i, data_req); end
            tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL exc%0d_valid got %b want 1", i, out_valid); end
            tests_run++; if (out_except_type !== exps[i]) begin tests_failed++; $display("[TB] FAIL exc%0d_except got %h want %h", i, out_except_type, exps[i]); end
            tests_run++; if (out_rw_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL exc%0d_rw_en got %b want 0", i, out_rw_en); end
            tick();
        end
    endtask

    task automatic test_flush_wait();
        out_ready = 1'b1;
        drive_payload(LSU_LD_W, 32'h500, 32'h4000, 32'h0, 1'b1, 5'd9, 10'h0);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        tests_run++; if (data_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL fw_req got %b want 1", data_req); end
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL fw_drain_valid_c%0d got %b want 0", c, out_valid); end
            tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL fw_drain_ready_c%0d got %b want 0", c, in_ready); end
            tests_run++; if (data_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL fw_drain_req_c%0d got %b want 0", c, data_req); end
            tick();
        end
        data_data_ok = 1'b1;
        data_rdata   = 32'h1111_1111;
        tick();
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
        @(negedge clk);
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL fw_ready_back got %b want 1", in_ready); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL fw_valid_after got %b want 0", out_valid); end
        tests_run++; if (out_result !== 32'h4000) begin tests_failed++; $display("[TB] FAIL fw_discard got %h want 00004000", out_result); end
        tick();
        @(negedge clk);
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL fw_valid_late got %b want 0", out_valid); end
    endtask

    task automatic test_flush_req_done();
        out_ready = 1'b1;
        // Flush in REQ without addr_ok: request withdrawn.
        drive_payload(LSU_LD_W, 32'h600, 32'h4100, 32'h0, 1'b1, 5'd10, 10'h0);
        tick();
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        tests_run++; if (data_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL fr_withdraw got %b want 0", data_req); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL fr_ready got %b want 1", in_ready); end
        // Flush in REQ with addr_ok: must drain the response.
        drive_payload(LSU_LD_W, 32'h604, 32'h4104, 32'h0, 1'b1, 5'd10, 10'h0);
        tick();
        in_valid = 1'b0;
        data_addr_ok = 1'b1;
        flush = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL fra_drain_ready got %b want 0", in_ready); end
        data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;
        @(negedge clk);
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL fra_ready_back got %b want 1", in_ready); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL fra_valid got %b want 0", out_valid); end
        // Flush in DONE: result dropped.
        out_ready = 1'b0;
        drive_payload(LSU_NONE, 32'h608, 32'h7777, 32'h0, 1'b1, 5'd11, 10'h0);
        tick();
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL fd_valid got %b want 0", out_valid); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL fd_ready got %b want 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive_payload(LSU_NONE, 32'h700, 32'hCAFE_0001, 32'h0, 1'b1, 5'd3, 10'h0);
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_valid_c%0d got %b want 1", c, out_valid); end
            tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_ready_c%0d got %b want 0", c, in_ready); end
            tests_run++; if (out_result !== 32'hCAFE_0001) begin tests_failed++; $display("[TB] FAIL bp_result_c%0d got %h want cafe0001", c, out_result); end
            tests_run++; if (out_rw_addr !== 5'd3) begin tests_failed++; $display("[TB] FAIL bp_rd_c%0d got %0d want 3", c, out_rw_addr); end
            tick();
        end
        out_ready = 1'b1;
        drive_payload(LSU_NONE, 32'h704, 32'h0000_5555, 32'h0, 1'b1, 5'd7, 10'h0);
        @(negedge clk);
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_valid got %b want 1", out_valid); end
        tests_run++; if (out_result !== 32'h5555) begin tests_failed++; $display("[TB] FAIL b2b_result got %h want 00005555", out_result); end
        tests_run++; if (out_rw_addr !== 5'd7) begin tests_failed++; $display("[TB] FAIL b2b_rd got %0d want 7", out_rw_addr); end
        tests_run++; if (out_pc !== 32'h704) begin tests_failed++; $display("[TB] FAIL b2b_pc got %h want 00000704", out_pc); end
        tick();
        @(negedge clk);
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_idle got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_ext();
        test_store();
        test_misaligned();
        test_flush_wait();
        test_flush_req_done();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
